// File: rtl/mem_port_arbiter.sv
// Arbiter for the core's single memory port: data has priority over fetch, with a starvation
// limit so fetch always progresses. One access at a time, IDLE -> BUSY -> RESP -> IDLE.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 5,
  parameter int STARVE_MAX  = 2
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            if_req,
  input  logic [31:0]     if_addr,
  output logic            if_ready,
  output logic [31:0]     if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [31:0]     d_addr,
  input  logic [3:0][7:0] d_wdata,
  output logic            d_ready,
  output logic [3:0][7:0] d_rdata,
  output logic [31:0]     mem_addr,
  output logic [3:0][7:0] mem_data_in,
  input  logic [3:0][7:0] mem_data_out,
  output logic            mem_write_en,
  output logic            busy,
  output logic            stall
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [STV_W-1:0]   starve;
  logic               own_data;
  logic               own_store;
  logic               grant;
  logic               grant_data;

  function automatic logic [STV_W-1:0] starve_inc(input logic [STV_W-1:0] s);
    if (s == STV_W'(STARVE_MAX)) return s;
    return s + STV_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grants are only taken from IDLE; fetch wins a tie once data has been favoured STARVE_MAX times.
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_data = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          grant      = 1'b1;
          grant_data = d_req && !(if_req && (starve == STV_W'(STARVE_MAX)));
          state_nxt  = BUSY;
        end
      end
      BUSY:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt          <= '0;
      starve       <= '0;
      own_data     <= 1'b0;
      own_store    <= 1'b0;
      mem_addr     <= '0;
      mem_data_in  <= '0;
      mem_write_en <= 1'b0;
      if_rdata     <= '0;
      d_rdata      <= '0;
    end else begin
      mem_write_en <= 1'b0;
      if (grant) begin
        own_data     <= grant_data;
        own_store    <= grant_data && d_we;
        mem_addr     <= grant_data ? d_addr : if_addr;
        mem_write_en <= grant_data && d_we;
        cnt          <= CNT_W'(MEM_LATENCY - 1);
        if (grant_data) mem_data_in <= d_wdata;
        if (!grant_data) starve <= '0;
        else if (if_req) starve <= starve_inc(starve);
      end else if (state == BUSY) begin
        if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end else if (!own_data) begin
          if_rdata <= mem_data_out;
        end else if (!own_store) begin
          d_rdata <= mem_data_out;
        end
      end
    end
  end

  assign busy     = (state != IDLE);
  assign if_ready = (state == RESP) && !own_data;
  assign d_ready  = (state == RESP) && own_data;
  assign stall    = (if_req && !if_ready) || (d_req && !d_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (latency 5 and latency 1) driven by random requesters
// and directed scenarios, checked cycle by cycle against a transaction-timing reference model.
module tb_mem_port_arbiter;

  localparam int NI = 2;
  localparam int L0 = 5;
  localparam int S0 = 2;
  localparam int L1 = 1;
  localparam int S1 = 1;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic        if_req       [NI];
  logic [31:0] if_addr      [NI];
  logic        d_req        [NI];
  logic        d_we         [NI];
  logic [31:0] d_addr       [NI];
  logic [31:0] d_wdata      [NI];
  logic [31:0] mem_data_out [NI];
  wire         if_ready     [NI];
  wire  [31:0] if_rdata     [NI];
  wire         d_ready      [NI];
  wire  [31:0] d_rdata      [NI];
  wire  [31:0] mem_addr     [NI];
  wire  [31:0] mem_data_in  [NI];
  wire         mem_write_en [NI];
  wire         busy         [NI];
  wire         stall        [NI];

  mem_port_arbiter #(.MEM_LATENCY(L0), .STARVE_MAX(S0)) dut0 (
    .clk(clk), .rst_b(rst_b),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ready(if_ready[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_ready(d_ready[0]), .d_rdata(d_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_data_in(mem_data_in[0]), .mem_data_out(mem_data_out[0]),
    .mem_write_en(mem_write_en[0]), .busy(busy[0]), .stall(stall[0])
  );

  mem_port_arbiter #(.MEM_LATENCY(L1), .STARVE_MAX(S1)) dut1 (
    .clk(clk), .rst_b(rst_b),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ready(if_ready[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_ready(d_ready[1]), .d_rdata(d_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_data_in(mem_data_in[1]), .mem_data_out(mem_data_out[1]),
    .mem_write_en(mem_write_en[1]), .busy(busy[1]), .stall(stall[1])
  );

  int total = 0;
  int bad   = 0;
  int n     = 0;

  int lat  [NI];
  int smax [NI];

  bit          m_act      [NI];
  int          g_edge     [NI];
  bit          g_data     [NI];
  bit          g_we       [NI];
  logic [31:0] g_addr     [NI];
  logic [31:0] g_wdata    [NI];
  int          starve     [NI];
  logic [31:0] e_if_rdata [NI];
  logic [31:0] e_d_rdata  [NI];
  logic [31:0] e_mem_addr [NI];

  int pr_if   [NI];
  int pr_d    [NI];
  int pr_st   [NI];
  int pr_drop [NI];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h40)  return 32'h0050_0093;
    if (a == 32'h200) return 32'h1234_5678;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_act[k]      = 1'b0;
      starve[k]     = 0;
      e_if_rdata[k] = '0;
      e_d_rdata[k]  = '0;
      e_mem_addr[k] = '0;
    end
  endtask

  // One access occupies edges g_edge .. g_edge+lat+1; the result is sampled at edge g_edge+lat.
  task automatic model_edge(input int k);
    bit fetch_wins;
    if (!m_act[k]) begin
      if (if_req[k] || d_req[k]) begin
        fetch_wins = if_req[k] && (!d_req[k] || starve[k] >= smax[k]);
        m_act[k]   = 1'b1;
        g_edge[k]  = n;
        g_data[k]  = !fetch_wins;
        g_we[k]    = !fetch_wins && d_we[k];
        g_addr[k]  = fetch_wins ? if_addr[k] : d_addr[k];
        g_wdata[k] = d_wdata[k];
        e_mem_addr[k] = g_addr[k];
        if (fetch_wins)     starve[k] = 0;
        else if (if_req[k]) starve[k] = (starve[k] < smax[k]) ? starve[k] + 1 : smax[k];
      end
    end else begin
      if (n == g_edge[k] + lat[k]) begin
        if (!g_data[k])   e_if_rdata[k] = memval(g_addr[k]);
        else if (!g_we[k]) e_d_rdata[k] = memval(g_addr[k]);
      end
      if (n == g_edge[k] + lat[k] + 1) m_act[k] = 1'b0;
    end
  endtask

  task automatic check(input int k);
    bit rdy, eif, ed, ewe, est;
    rdy = m_act[k] && (n == g_edge[k] + lat[k]);
    eif = rdy && !g_data[k];
    ed  = rdy && g_data[k];
    ewe = m_act[k] && (n == g_edge[k]) && g_we[k];
    est = (if_req[k] && !eif) || (d_req[k] && !ed);
    chk1($sformatf("busy%0d", k), busy[k], m_act[k]);
    chk1($sformatf("if_ready%0d", k), if_ready[k], eif);
    chk1($sformatf("d_ready%0d", k), d_ready[k], ed);
    chk1($sformatf("mem_we%0d", k), mem_write_en[k], ewe);
    chk1($sformatf("stall%0d", k), stall[k], est);
    chk($sformatf("if_rdata%0d", k), if_rdata[k], e_if_rdata[k]);
    chk($sformatf("d_rdata%0d", k), d_rdata[k], e_d_rdata[k]);
    chk($sformatf("mem_addr%0d", k), mem_addr[k], e_mem_addr[k]);
    if (ewe) chk($sformatf("mem_din%0d", k), mem_data_in[k], g_wdata[k]);
  endtask

  task automatic requesters(input int k);
    bit rdy_if, rdy_d;
    rdy_if = m_act[k] && (n == g_edge[k] + lat[k]) && !g_data[k];
    rdy_d  = m_act[k] && (n == g_edge[k] + lat[k]) && g_data[k];
    if (!if_req[k] || rdy_if) begin
      if_req[k]  = ($urandom_range(99) < pr_if[k]);
      if_addr[k] = $urandom;
    end else if ($urandom_range(999) < pr_drop[k]) begin
      if_req[k] = 1'b0;
    end
    if (!d_req[k] || rdy_d) begin
      d_req[k]   = ($urandom_range(99) < pr_d[k]);
      d_we[k]    = ($urandom_range(99) < pr_st[k]);
      d_addr[k]  = $urandom;
      d_wdata[k] = $urandom;
    end else if ($urandom_range(999) < pr_drop[k]) begin
      d_req[k] = 1'b0;
    end
  endtask

  // Memory only presents valid data in the cycle before the capture edge; garbage otherwise.
  task automatic drive_mem(input int k);
    if (m_act[k] && (n == g_edge[k] + lat[k] - 1)) mem_data_out[k] = memval(g_addr[k]);
    else                                           mem_data_out[k] = $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    for (int k = 0; k < NI; k++) model_edge(k);
    #1;
    for (int k = 0; k < NI; k++) check(k);
    for (int k = 0; k < NI; k++) requesters(k);
    for (int k = 0; k < NI; k++) drive_mem(k);
  endtask

  task automatic wait_ready(input int k, input bit data, output int steps, output int wes);
    steps = 0;
    wes   = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      steps++;
      if (mem_write_en[k] === 1'b1) wes++;
      if ((data ? d_ready[k] : if_ready[k]) === 1'b1) return;
    end
    chk1($sformatf("ready_timeout%0d", k), 1'b0, 1'b1);
  endtask

  task automatic wait_idle0();
    for (int i = 0; i < 100; i++) begin
      if (!m_act[0] && !if_req[0] && !d_req[0]) return;
      step();
    end
    chk1("idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk1($sformatf("%s_busy%0d", tag, k), busy[k], 1'b0);
      chk1($sformatf("%s_ifrdy%0d", tag, k), if_ready[k], 1'b0);
      chk1($sformatf("%s_drdy%0d", tag, k), d_ready[k], 1'b0);
      chk1($sformatf("%s_we%0d", tag, k), mem_write_en[k], 1'b0);
      chk($sformatf("%s_addr%0d", tag, k), mem_addr[k], 32'h0);
      chk($sformatf("%s_din%0d", tag, k), mem_data_in[k], 32'h0);
      chk($sformatf("%s_ifrd%0d", tag, k), if_rdata[k], 32'h0);
      chk($sformatf("%s_drd%0d", tag, k), d_rdata[k], 32'h0);
    end
  endtask

  // Store on instance 0, then reset nb cycles into its BUSY phase; the still-held request restarts.
  task automatic reset_mid_store(input int nb);
    int steps, wes;
    wait_idle0();
    d_req[0]   = 1'b1;
    d_we[0]    = 1'b1;
    d_addr[0]  = 32'h100;
    d_wdata[0] = $urandom;
    for (int i = 0; i < nb; i++) step();
    #3;
    rst_b = 1'b0;
    #1;
    check_reset_outputs($sformatf("rst_mid%0d", nb));
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    model_reset();
    wait_ready(0, 1'b1, steps, wes);
    chk($sformatf("rst_regrant_lat%0d", nb), steps, L0 + 1);
    chk($sformatf("rst_regrant_we%0d", nb), wes, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int steps, wes, cnt, last, gaps;
    logic [31:0] got, saved;

    lat[0] = L0; lat[1] = L1;
    smax[0] = S0; smax[1] = S1;
    for (int k = 0; k < NI; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
      mem_data_out[k] = '0;
      pr_if[k] = 0; pr_d[k] = 0; pr_st[k] = 0; pr_drop[k] = 0;
    end
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_b = 1'b1;

    pr_if[1] = 30; pr_d[1] = 40; pr_st[1] = 40; pr_drop[1] = 5;

    // Fetch alone: ready L0+1 steps after raising, data from the memory word at 0x40.
    if_req[0] = 1'b1; if_addr[0] = 32'h40;
    wait_ready(0, 1'b0, steps, wes);
    chk("fetch_latency", steps, L0 + 1);
    chk("fetch_data", if_rdata[0], 32'h0050_0093);

    // Single store: one write strobe, d_rdata untouched.
    saved = d_rdata[0];
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h100; d_wdata[0] = 32'hDEAD_BEEF;
    wait_ready(0, 1'b1, steps, wes);
    chk("store_we_cycles", wes, 1);
    chk("store_rdata_kept", d_rdata[0], saved);
    chk("store_addr_held", mem_addr[0], 32'h100);
    chk("store_wdata", mem_data_in[0], 32'hDEAD_BEEF);

    // Both requesters held: D,D,F,D,D,F.
    pr_if[0] = 100; pr_d[0] = 100; pr_st[0] = 0;
    if_req[0] = 1'b1; if_addr[0] = $urandom;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = $urandom;
    got = '0;
    cnt = 0;
    for (int i = 0; i < 100 && cnt < 6; i++) begin
      step();
      if (d_ready[0] === 1'b1 || if_ready[0] === 1'b1) begin
        got[cnt] = d_ready[0];
        cnt++;
      end
    end
    chk("grant_count", cnt, 6);
    chk("grant_order", got, 32'b01_1011);
    pr_if[0] = 0; pr_d[0] = 0;
    wait_idle0();

    // Load then immediate fetch: one idle cycle between accesses.
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h200;
    wait_ready(0, 1'b1, steps, wes);
    chk("load_data", d_rdata[0], 32'h1234_5678);
    if_req[0] = 1'b1; if_addr[0] = 32'h40;
    wait_ready(0, 1'b0, steps, wes);
    chk("fetch_after_load_gap", steps, L0 + 2);
    chk("fetch_after_load_data", if_rdata[0], 32'h0050_0093);

    // Latency-1 instance, back-to-back loads every L1+2 cycles.
    pr_if[1] = 0; pr_d[1] = 100; pr_st[1] = 0; pr_drop[1] = 0;
    repeat (30) step();
    last = -1;
    gaps = 0;
    for (int i = 0; i < 40 && gaps < 4; i++) begin
      step();
      if (d_ready[1] === 1'b1) begin
        if (last >= 0) begin
          chk("ml1_load_gap", n - last, L1 + 2);
          gaps++;
        end
        last = n;
      end
    end
    chk("ml1_gaps_seen", gaps, 4);

    // Random traffic on both instances.
    for (int k = 0; k < NI; k++) begin
      pr_if[k] = 35; pr_d[k] = 45; pr_st[k] = 40; pr_drop[k] = 3;
    end
    repeat (2500) step();

    // Asynchronous reset during the first and second BUSY cycles of a store.
    pr_if[0] = 0; pr_d[0] = 0; pr_drop[0] = 0;
    reset_mid_store(1);
    reset_mid_store(2);
    repeat (50) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
